// File: rtl/m31_pkg.sv
// rtl/m31_pkg.sv - shared M31 field types, constants and inverter state encoding
package m31_pkg;

    typedef logic [30:0] m31_t;

    localparam m31_t P_M31       = 31'h7FFFFFFF;
    localparam m31_t M31_INV_EXP = 31'h7FFFFFFD;
    localparam int   M31_MUL_LAT = 5;
    localparam int   M31_INV_LAT = 1 + 59 * M31_MUL_LAT;

    typedef enum logic [1:0] {
        IDLE,
        SQR,
        MUL,
        DONE
    } inv_state_t;

endpackage

// File: rtl/m31_mul.sv
// rtl/m31_mul.sv - 5-stage pipelined M31 multiplier, canonical operands in, canonical product out
module m31_mul
    import m31_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  m31_t a,
    input  m31_t b,
    output m31_t p
);

    m31_t        a1;
    m31_t        b1;
    logic [61:0] prod2;
    logic [31:0] sum3;
    m31_t        fold4;

    // 2^31 == 1 mod P, so folding the high half onto the low half reduces the product
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a1    <= '0;
            b1    <= '0;
            prod2 <= '0;
            sum3  <= '0;
            fold4 <= '0;
            p     <= '0;
        end else begin
            a1    <= a;
            b1    <= b;
            prod2 <= 62'(a1) * 62'(b1);
            sum3  <= 32'(prod2[30:0]) + 32'(prod2[61:31]);
            fold4 <= sum3[30:0] + 31'(sum3[31]);
            p     <= (fold4 == P_M31) ? '0 : fold4;
        end
    end

endmodule

// File: rtl/m31_inv.sv
// rtl/m31_inv.sv - iterative M31 inverter, a^(P-2) by square-and-multiply on one shared multiplier
module m31_inv
    import m31_pkg::*;
#(
    parameter int MUL_LAT = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  m31_t in_data,
    output logic out_valid,
    input  logic out_ready,
    output m31_t out_data,
    output logic out_dz
);

    localparam int             CW   = $clog2(MUL_LAT);
    localparam logic [CW-1:0]  LAST = CW'(MUL_LAT - 1);

    inv_state_t    state;
    inv_state_t    state_nxt;
    m31_t          base;
    m31_t          acc;
    m31_t          base_nxt;
    m31_t          acc_nxt;
    m31_t          in_red;
    m31_t          mul_a;
    m31_t          mul_b;
    m31_t          mul_p;
    logic [4:0]    k;
    logic [CW-1:0] cnt;
    logic          dz;
    logic          accept;
    logic          busy;
    logic          capture;
    logic          exp_bit;

    assign accept  = in_valid & in_ready;
    assign busy    = (state == SQR) || (state == MUL);
    assign capture = busy && (cnt == LAST);
    assign exp_bit = M31_INV_EXP[k];
    assign in_red  = (in_data == P_M31) ? '0 : in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            base  <= '0;
            k     <= '0;
            cnt   <= '0;
            dz    <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            base  <= base_nxt;
            if (accept) begin
                k   <= 5'd29;
                cnt <= '0;
                dz  <= (in_red == '0);
            end else if (capture) begin
                cnt <= '0;
                if (state_nxt == SQR)
                    k <= k - 5'd1;
            end else if (busy) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = SQR;
            SQR: if (capture) begin
                if (exp_bit)        state_nxt = MUL;
                else if (k == 5'd0) state_nxt = DONE;
            end
            MUL: if (capture) state_nxt = (k == 5'd0) ? DONE : SQR;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are fed from next-cycle values so the multiplier's input stage
    // loads on the same edge as acc, making each operation exactly MUL_LAT cycles.
    always_comb begin
        base_nxt = base;
        acc_nxt  = acc;
        if (accept) begin
            base_nxt = in_red;
            acc_nxt  = in_red;
        end else if (capture) begin
            acc_nxt = mul_p;
        end
        mul_a = acc_nxt;
        mul_b = (state_nxt == MUL) ? base_nxt : acc_nxt;
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        out_dz    = (state == DONE) && dz;
        out_data  = ((state == DONE) && !dz) ? acc : '0;
    end

    m31_mul u_mul (
        .clk   (clk),
        .rst_n (~rst),
        .a     (mul_a),
        .b     (mul_b),
        .p     (mul_p)
    );

endmodule

// File: tb/tb_m31_inv.sv
// tb/tb_m31_inv.sv - self-checking bench for m31_inv with vector table and output scoreboard
module tb_m31_inv;

    localparam logic [30:0] P       = 31'h7FFFFFFF;
    localparam int          LAT     = 296;
    localparam int          II      = 297;
    localparam int          N_RAND  = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [30:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [30:0] out_data;
    logic        out_dz;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [30:0] a;
        logic [30:0] exp_data;
        logic        exp_dz;
        logic        is_rand;
        int          acc_cyc;
    } sb_t;

    typedef struct {
        logic [30:0] a;
        logic [30:0] exp_data;
        logic        exp_dz;
    } vec_t;

    sb_t  sb[$];
    vec_t vecs[7];

    logic [30:0] cur_exp;
    logic        cur_dz;
    logic        cur_rand;
    logic        b2b = 1'b0;
    logic        have_prev = 1'b0;
    int          prev_acc = 0;
    int          first_cyc = 0;
    logic        ov_prev = 1'b0;

    m31_inv dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_dz    (out_dz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: push on input handshake, pop and compare on output handshake.
    always @(negedge clk) begin
        sb_t e;
        if (rst) begin
            ov_prev = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                e.a = in_data; e.exp_data = cur_exp; e.exp_dz = cur_dz;
                e.is_rand = cur_rand; e.acc_cyc = cyc;
                sb.push_back(e);
                if (b2b && have_prev) chk("throughput", 64'(cyc - prev_acc), 64'(II));
                prev_acc = cyc;
                have_prev = 1'b1;
            end
            if (out_valid && !ov_prev) first_cyc = cyc;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 64'(out_data), 64'(P));
                end else begin
                    e = sb.pop_front();
                    chk("latency", 64'(first_cyc - e.acc_cyc), 64'(LAT));
                    chk("canonical", 64'(out_data < P), 64'd1);
                    if (e.is_rand) begin
                        chk("inv_product", (64'(e.a) * 64'(out_data)) % 64'(P), 64'd1);
                        chk("rand_dz", 64'(out_dz), 64'd0);
                    end else begin
                        chk("out_data", 64'(out_data), 64'(e.exp_data));
                        chk("out_dz", 64'(out_dz), 64'(e.exp_dz));
                    end
                end
            end
            ov_prev = out_valid;
        end
    end

    task automatic send(input logic [30:0] a, input logic [30:0] e, input logic d, input logic r);
        int n;
        cur_exp = e; cur_dz = d; cur_rand = r;
        in_data = a; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int n;
        vecs[0] = '{31'd1,          31'd1,          1'b0};
        vecs[1] = '{31'd2,          31'd1073741824, 1'b0};
        vecs[2] = '{31'd3,          31'd1431655765, 1'b0};
        vecs[3] = '{31'd2147483646, 31'd2147483646, 1'b0};
        vecs[4] = '{31'd0,          31'd0,          1'b1};
        vecs[5] = '{31'd2147483647, 31'd0,          1'b1};
        vecs[6] = '{31'd5,          31'd858993459,  1'b0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_dz", 64'(out_dz), 64'd0);

        foreach (vecs[i]) begin
            send(vecs[i].a, vecs[i].exp_data, vecs[i].exp_dz, 1'b0);
            wait_idle();
        end

        // Output backpressure: result must hold and no new operand may enter.
        out_ready = 1'b0;
        send(31'd7, 31'd1840700269, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_valid_seen", 64'(out_valid), 64'd1);
        cur_exp = '0; cur_dz = 1'b0; cur_rand = 1'b1;
        in_data = 31'd9; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_data", 64'(out_data), 64'd1840700269);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_in_ready_after", 64'(in_ready), 64'd1);
        chk("bp_valid_dropped", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_idle();

        // Reset mid-operation: abort silently, then a fresh operand completes normally.
        send(31'd11, '0, 1'b0, 1'b1);
        repeat (100) @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        have_prev = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        send(31'd5, 31'd858993459, 1'b0, 1'b0);
        wait_idle();

        // Random sweep, back-to-back with out_ready held high.
        b2b = 1'b1;
        have_prev = 1'b0;
        for (int i = 0; i < N_RAND; i++)
            send(31'($urandom_range(32'h7FFFFFFE, 32'd1)), '0, 1'b0, 1'b1);
        wait_idle();
        b2b = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
